// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-word pipeline.
// Holds the control-word layout, ARM condition codes, data-processing
// opcodes and the condition evaluation function.
package ctrl_pkg;

  // Width of one packed control word
  localparam int CW_W = 14;

  // Bit positions inside a control word
  localparam int CW_VALID  = 0;
  localparam int CW_B      = 1;
  localparam int CW_BL     = 2;
  localparam int CW_MEM    = 3;
  localparam int CW_RW     = 4;
  localparam int CW_SIZE   = 5;
  localparam int CW_RF     = 6;
  localparam int CW_LOAD   = 7;
  localparam int CW_S      = 8;
  localparam int CW_AM     = 9;
  localparam int CW_OP_LO  = 10;
  localparam int CW_OP_HI  = 13;

  // Field view of a control word, MSB first (matches the bit positions above)
  typedef struct packed {
    logic [3:0] opcode;
    logic       am;
    logic       s_enable;
    logic       load_instr;
    logic       rf_enable;
    logic       size_enable;
    logic       rw_enable;
    logic       mem_enable;
    logic       bl_instr;
    logic       b_instr;
    logic       valid;
  } ctrl_word_t;

  // ARM condition field encodings
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Data-processing opcodes the decoder cares about
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;

  // Evaluate an ARM condition field against {N,Z,C,V}; 1111 never passes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the ID-stage instruction into a control word,
// followed by qualification against the condition field and NZCV flags.
// A failing condition turns the instruction into an all-zero word; the
// undefined indication depends only on the encoding, not on the condition.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit COND_EN = 1'b1
) (
  input  logic [31:0]     i_instr,
  input  logic [3:0]      i_flags,
  output logic [CW_W-1:0] o_word,
  output logic [CW_W-1:0] o_word_raw,
  output logic            o_undef
);

  ctrl_word_t w_dec;
  logic       w_undef;
  logic       w_pass;
  logic       w_is_dp;
  logic       w_is_ls;
  logic       w_is_br;

  // Multiply/extra load-store space (bit25=0, bit7=1, bit4=1) is not data processing
  assign w_is_dp = (i_instr[27:26] == 2'b00) &&
                   !(~i_instr[25] && i_instr[7] && i_instr[4]);
  assign w_is_ls = (i_instr[27:26] == 2'b01);
  assign w_is_br = (i_instr[27:25] == 3'b101);

  // Class decode; each decoded class yields a non-zero word with valid set
  always_comb begin
    w_dec   = '0;
    w_undef = 1'b0;
    if (i_instr == 32'h0) begin
      w_dec = '0;
    end else if (w_is_dp) begin
      w_dec.opcode    = i_instr[24:21];
      w_dec.am        = i_instr[25];
      w_dec.s_enable  = i_instr[20];
      w_dec.rf_enable = !(i_instr[24:21] inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
      w_dec.valid     = 1'b1;
    end else if (w_is_ls) begin
      w_dec.load_instr  = i_instr[20];
      w_dec.rf_enable   = i_instr[20];
      w_dec.rw_enable   = ~i_instr[20];
      w_dec.size_enable = i_instr[22];
      w_dec.mem_enable  = 1'b1;
      w_dec.am          = i_instr[25];
      w_dec.opcode      = i_instr[23] ? OP_ADD : OP_SUB;
      w_dec.valid       = 1'b1;
    end else if (w_is_br) begin
      w_dec.bl_instr  = i_instr[24];
      w_dec.b_instr   = ~i_instr[24];
      w_dec.rf_enable = i_instr[24];
      w_dec.opcode    = OP_ADD;
      w_dec.valid     = 1'b1;
    end else begin
      w_undef = 1'b1;
    end
  end

  // With condition evaluation disabled every instruction behaves as AL
  assign w_pass = COND_EN ? cond_pass(i_instr[31:28], i_flags) : 1'b1;

  assign o_word     = w_pass ? w_dec : '0;
  assign o_word_raw = w_dec;
  assign o_undef    = w_undef;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Control pipeline: decodes the ID instruction, qualifies it, and carries
// the resulting control word through NUM_STAGES registers (stage 0 = EX).
// NUM_STAGES is meant to be 1..5.
//
// Interface timing: there is no handshake. hold, stall, flush and cnt_clr
// are level-sensitive and sampled at the rising edge. Priority is
// reset > hold > (stall | flush) > normal; hold freezes every stage and
// the bubble counter, stall or flush inserts one zero word into stage 0.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter bit COND_EN    = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                instr_id,
  input  logic [3:0]                 flags,
  input  logic                       hold,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       cnt_clr,
  output logic [NUM_STAGES*CW_W-1:0] stage_ctrl,
  output logic                       branch_taken,
  output logic                       undef_id,
  output logic [CNT_W-1:0]           bubble_cnt
);

  logic [CW_W-1:0]                  w_word;
  logic [CW_W-1:0]                  w_word_raw;
  logic                             w_undef;
  logic [CW_W-1:0]                  w_stage0_in;
  logic                             w_bubble;
  logic [NUM_STAGES:0][CW_W-1:0]    w_chain;
  logic [CNT_W-1:0]                 r_bubble_cnt;
  logic                             w_unused_raw;

  ctrl_decode #(
    .COND_EN (COND_EN)
  ) u_decode (
    .i_instr    (instr_id),
    .i_flags    (flags),
    .o_word     (w_word),
    .o_word_raw (w_word_raw),
    .o_undef    (w_undef)
  );

  // The unqualified word is only exported for debug probing
  assign w_unused_raw = ^w_word_raw;

  assign w_stage0_in = (stall || flush) ? '0 : w_word;
  assign w_bubble    = ~w_stage0_in[CW_VALID];
  assign w_chain[0]  = w_stage0_in;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [CW_W-1:0] r_q;

    // Stage register: advances from the previous stage unless held
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_q <= '0;
      end else if (!hold) begin
        r_q <= w_chain[k];
      end
    end

    assign w_chain[k+1]              = r_q;
    assign stage_ctrl[k*CW_W +: CW_W] = r_q;
  end

  // Bubble counter: counts zero-valid loads into stage 0, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bubble_cnt <= '0;
    end else if (!hold) begin
      if (cnt_clr) begin
        r_bubble_cnt <= '0;
      end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign bubble_cnt = r_bubble_cnt;

  // A redirect is only reported when the branch will really enter EX
  assign branch_taken = reset_n && (w_word[CW_B] || w_word[CW_BL]) &&
                        !stall && !flush && !hold;
  assign undef_id     = w_undef;

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Parametrised successor to the single-cycle ARM control decoder. It decodes the instruction held in the ID stage into a packed control word and qualifies it against the condition field and current NZCV flags. The word is then carried through NUM_STAGES pipeline registers (EX, MEM, WB, …), with hold, stall-bubble and flush handling plus a bubble-cycle counter. It sits between the IF/ID register and the datapath stage muxes.

## Interface
- NUM_STAGES, 3, number of control register stages after ID (legal 1–5); stage 0 = EX.
- COND_EN, 1, 1: evaluate cond field; 0: treat every instruction as AL.
- CNT_W, 16, width of bubble counter.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_id  in  32  instruction currently in ID.
- flags  in  4  current {N,Z,C,V}.
- hold  in  1  freeze all stage registers and counter.
- stall  in  1  load-use stall: bubble enters stage 0.
- flush  in  1  squash ID instruction: bubble enters stage 0.
- cnt_clr  in  1  synchronous clear of bubble_cnt.
- stage_ctrl  out  NUM_STAGES*14  packed control words; stage k at [14k+13:14k].
- branch_taken  out  1  combinational: ID holds B/BL, condition passes, no stall/flush/hold.
- undef_id  out  1  combinational: ID instruction matches no decode class.
- bubble_cnt  out  CNT_W  saturating count of cycles a bubble entered stage 0.

## Operation
- Control word, bits 13..0: opcode[3:0], am, s_enable, load_instr, rf_enable, size_enable, rw_enable, mem_enable, bl_instr, b_instr, valid.
- Decode from i = instr_id:
  - **All-zero instruction:** NOP. Word is 0.
  - **Data processing** (i[27:26]=00, excluding i[25]=0 & i[7]=1 & i[4]=1): opcode=i[24:21], am=i[25], s_enable=i[20], rf_enable=1 except opcode 1000–1011 (TST/TEQ/CMP/CMN) → 0.
  - **Load/store word/byte** (i[27:26]=01): load_instr=i[20], rf_enable=i[20], rw_enable=~i[20] (1 = write), size_enable=i[22] (1 = byte), mem_enable=1, am=i[25], opcode=0100 if i[23] else 0010.
  - **Branch** (i[27:25]=101): bl_instr=i[24], b_instr=~i[24], rf_enable=i[24], opcode=0100.
  - **Otherwise:** word 0, undef_id=1.
  - valid=1 for any non-zero decoded word.
- Condition (COND_EN=1): standard ARM EQ..AL on flags; 1111 treated as never. Failing condition → word forced to 0.
- Stage 0 input:
  - 0 if stall or flush;
  - else the qualified decoded word.
- Stage k>0 input: stage k-1.
- Priority: reset > hold > (flush | stall) > normal.
- bubble_cnt increments when stage 0 loads a word with valid=0, hold is low and cnt_clr is low. It saturates at all-ones. cnt_clr has priority over increment.

## Timing
- Reset: all stage registers 0, bubble_cnt 0, immediately on reset_n low. Reset mid-operation discards in-flight words; first valid word appears in stage 0 one edge after reset_n rises with a valid instruction in ID.
- Latency: ID → stage k output = k+1 rising edges.
- hold=1: all registers and bubble_cnt unchanged. branch_taken forced 0.
- stall and flush simultaneous: single bubble, counted once.
- Back-to-back stalls: one bubble per cycle, each counted.
- No handshake beyond level-sensitive inputs sampled at the rising edge.

## Structure
- Package ctrl_pkg: CW_W=14, bit-index constants for each field, cond-code constants, opcode constants (ADD, SUB, TST..CMN), and function cond_pass(cond, flags).
- Sub-module ctrl_decode: combinational decode plus condition qualification, outputs word and undef. The top holds the stage shift register (generate loop over NUM_STAGES) and the counter.

## Test plan
- Reset with NUM_STAGES=3; drive E0810002 (ADD r0,r1,r2): stage 0 opcode=0100, rf_enable=1, valid=1 after 1 edge; same word at stage 2 after 3 edges.
- E5910000 (LDR r0,[r1]) then E5C10000 (STRB): load word has load_instr=1, rf_enable=1, mem_enable=1, size_enable=0; store word has rw_enable=1, size_enable=1, rf_enable=0.
- flags Z=0, instr 0A000004 (BEQ): branch_taken=0, stage 0 word 0, bubble_cnt 0→1. With Z=1: branch_taken=1, b_instr=1.
- stall=1 for 2 cycles on a valid instruction stream: two zero words enter stage 0, bubble_cnt +2. Later stages keep advancing.
- hold=1 for 3 cycles: stage_ctrl and bubble_cnt frozen. stall during hold has no effect.
- CNT_W=4, 20 forced bubbles: bubble_cnt saturates at 15. cnt_clr → 0 next edge. Assert reset_n low mid-stream: all outputs 0 asynchronously.
